fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 The module SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 imem_req  output  1  registered instruction-fetch request.
REQ-005 imem_addr  output  32  registered fetch address, equal to pc while imem_req=1.
REQ-006 imem_ack  input  1  fetch complete; imem_data is valid in the same cycle.
REQ-007 imem_data  input  32  fetched instruction word.
REQ-008 iout  output  32  instruction register presented to the decoder.
REQ-009 ivalid  output  1  one-cycle strobe: iout is new, and the decoder samples it.
REQ-010 ib  input  1  branch taken, from the decoder (registered, condition already passed).
REQ-011 bv  input  32  signed branch byte offset, already shifted left by 2.
REQ-012 bl  input  1  branch-with-link.
REQ-013 stall  input  1  hold execute; the PC does not advance.
REQ-014 link_we  output  1  one-cycle write strobe for r14.
REQ-015 link_data  output  32  return address for r14.
REQ-016 pc  output  32  current program counter.
REQ-017 retire_cnt  output  16  count of retired instructions.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, ISSUE and EXEC, held in a registered state variable.
REQ-019 IDLE: the FSM SHALL unconditionally enter FETCH on the next cycle, with imem_req<=1 and imem_addr<=pc.
REQ-020 FETCH: imem_req and imem_addr SHALL hold stable until imem_ack=1.
REQ-021 In FETCH, on imem_ack=1: iout<=imem_data, imem_req<=0, and the FSM SHALL go to ISSUE.
REQ-022 imem_ack SHALL be ignored in every state except FETCH.
REQ-023 ISSUE: ivalid SHALL be 1 for exactly this cycle, and the FSM SHALL go to EXEC.
REQ-024 EXEC is one cycle after ISSUE; ib, bv and bl SHALL be sampled here, since the decoder output is registered.
REQ-025 EXEC with stall=1: the FSM SHALL remain in EXEC; pc, link and retire_cnt SHALL not change.
REQ-026 If stall and ib are asserted in the same cycle, stall SHALL win; the branch is evaluated on the first cycle with stall=0, and the decoder holds ib/bv/bl meanwhile.
REQ-027 EXEC with stall=0 and ib=0: pc<=pc+4.
REQ-028 EXEC with stall=0 and ib=1: pc<=(pc+8+bv), with bits [1:0] forced to 0, to account for the pipeline offset.
REQ-029 EXEC with stall=0, ib=1 and bl=1: link_we=1 for one cycle, and link_data<=pc+4 (the pre-update pc).
REQ-030 bl SHALL be ignored when ib=0.
REQ-031 In every EXEC exit (stall=0), retire_cnt SHALL increment by 1, and the FSM SHALL go to FETCH with imem_req<=1 and imem_addr<=the new pc.
REQ-032 All pc arithmetic SHALL be modulo 2^32; for example, 0xFFFFFFFC+4 gives 0x00000000.
REQ-033 retire_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-034 ivalid and link_we SHALL never both be 1 in the same cycle.
REQ-035 imem_req SHALL never be 1 outside FETCH.

Reset
REQ-036 rst=1 SHALL set: state=IDLE, pc=0, imem_req=0, imem_addr=0, iout=0, ivalid=0, link_we=0, link_data=0, retire_cnt=0.
REQ-037 rst SHALL override all other inputs in any state.
REQ-038 Reset during a FETCH SHALL abandon the request; a late imem_ack in IDLE SHALL be ignored.
REQ-039 The first request after reset release SHALL be issued 1 cycle after IDLE, at address 0.

Structure
REQ-040 A shared package cpu_pkg SHALL hold the FSM state enum and the constants PC_RESET=0, PC_STEP=4 and PC_PIPE_OFS=8.
REQ-041 The block SHALL be a single module with no sub-modules; the pc adder is inline.

Verification
REQ-042 Reset, then release: pc=0, and imem_req=1 with imem_addr=0 on the cycle after IDLE; ivalid stays 0 until imem_ack.
REQ-043 Sequential flow: ack delayed 2 cycles at pc=0 with ib=0 -> ivalid pulses once, pc=4, retire_cnt=1, next imem_addr=4.
REQ-044 Branch: pc=0x20, ib=1, bv=0x10 -> pc=0x38, link_we stays 0.
REQ-045 Branch-with-link: pc=0x100, ib=1, bl=1, bv=0xFFFFFFF8 -> pc=0x100, link_we pulses once, link_data=0x104.
REQ-046 Stall and wrap: pc=0xFFFFFFFC, stall=1 for 3 cycles together with ib=0 -> pc holds for 3 cycles, then becomes 0x00000000; retire_cnt increments once.
REQ-047 Reset mid-fetch: rst pulsed while in FETCH, then imem_ack=1 in IDLE -> iout unchanged at 0, ivalid=0, and the next request is at address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, PC constants and the
// branch-target helper used by the fetch sequencer.
package cpu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RCW   = 16;

  localparam logic [XLEN-1:0] PC_RESET    = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP     = 32'h0000_0004;
  localparam logic [XLEN-1:0] PC_PIPE_OFS = 32'h0000_0008;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_EXEC  = 2'd3
  } fetch_state_e;

  // Target is relative to pc+8 (two-stage pipeline view); word-align the result.
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] ofs);
    logic [XLEN-1:0] t;
    t = pc + PC_PIPE_OFS + ofs;
    return {t[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: fetches one word, issues it to the decoder,
// then waits in EXEC for the (possibly stalled) branch decision.
module fetch_seq
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [XLEN-1:0]      imem_data,
  output logic [XLEN-1:0]      iout,
  output logic                 ivalid,
  input  logic                 ib,
  input  logic [XLEN-1:0]      bv,
  input  logic                 bl,
  input  logic                 stall,
  output logic                 link_we,
  output logic [XLEN-1:0]      link_data,
  output logic [XLEN-1:0]      pc,
  output logic [RCW-1:0]       retire_cnt
);

  fetch_state_e    state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] iout_q, iout_d;
  logic            ivalid_q, ivalid_d;
  logic            link_we_q, link_we_d;
  logic [XLEN-1:0] link_data_q, link_data_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [RCW-1:0]  retire_q, retire_d;

  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_next;

  assign pc_seq  = pc_q + PC_STEP;
  assign pc_next = ib ? branch_target(pc_q, bv) : pc_seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      iout_q      <= '0;
      ivalid_q    <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      pc_q        <= PC_RESET;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      iout_q      <= iout_d;
      ivalid_q    <= ivalid_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      pc_q        <= pc_d;
      retire_q    <= retire_d;
    end
  end

  // Strobes (ivalid, link_we) default low so they last exactly one cycle.
  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    iout_d      = iout_q;
    ivalid_d    = 1'b0;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
    pc_d        = pc_q;
    retire_d    = retire_q;

    case (state_q)
      ST_IDLE: begin
        state_d     = ST_FETCH;
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          iout_d     = imem_data;
          imem_req_d = 1'b0;
          ivalid_d   = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Stall wins over a pending branch; decoder holds ib/bv/bl meanwhile.
        if (!stall) begin
          pc_d        = pc_next;
          retire_d    = retire_q + RCW'(1);
          state_d     = ST_FETCH;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_next;
          if (ib && bl) begin
            link_we_d   = 1'b1;
            link_data_d = pc_seq;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign iout       = iout_q;
  assign ivalid     = ivalid_q;
  assign link_we    = link_we_q;
  assign link_data  = link_data_q;
  assign pc         = pc_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq; inputs driven and outputs
// sampled on the falling edge.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] iout;
  logic        ivalid;
  logic        ib;
  logic [31:0] bv;
  logic        bl;
  logic        stall;
  logic        link_we;
  logic [31:0] link_data;
  logic [31:0] pc;
  logic [15:0] retire_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_link;
  logic [15:0] exp_ret;

  fetch_seq dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .iout       (iout),
    .ivalid     (ivalid),
    .ib         (ib),
    .bv         (bv),
    .bl         (bl),
    .stall      (stall),
    .link_we    (link_we),
    .link_data  (link_data),
    .pc         (pc),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", 32'(imem_req), 32'd1);
  endtask

  task automatic check_reset_vals();
    chk("rst_pc",        pc,                 32'h0);
    chk("rst_req",       32'(imem_req),      32'h0);
    chk("rst_addr",      imem_addr,          32'h0);
    chk("rst_iout",      iout,               32'h0);
    chk("rst_ivalid",    32'(ivalid),        32'h0);
    chk("rst_link_we",   32'(link_we),       32'h0);
    chk("rst_link_data", link_data,          32'h0);
    chk("rst_retire",    32'(retire_cnt),    32'h0);
  endtask

  // One fetch/issue/exec round; npc is the hand-computed next pc.
  task automatic run_instr(input int dly, input logic [31:0] word,
                           input logic b, input logic l, input logic [31:0] ofs,
                           input int nst, input logic [31:0] npc);
    wait_req();
    chk("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < dly; i++) begin
      chk("ivalid_wait", 32'(ivalid), 32'h0);
      chk("req_hold",    32'(imem_req), 32'h1);
      chk("addr_hold",   imem_addr, exp_pc);
      @(negedge clk);
    end
    imem_ack  = 1'b1;
    imem_data = word;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = $urandom;
    chk("ivalid_issue", 32'(ivalid), 32'h1);
    chk("iout",         iout, word);
    chk("req_drop",     32'(imem_req), 32'h0);
    ib    = b;
    bl    = l;
    bv    = ofs;
    stall = (nst != 0);
    @(negedge clk);
    chk("ivalid_pulse", 32'(ivalid), 32'h0);
    for (int i = 0; i < nst; i++) begin
      @(negedge clk);
      chk("pc_stall",     pc, exp_pc);
      chk("retire_stall", 32'(retire_cnt), 32'(exp_ret));
      chk("req_stall",    32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    if (b && l) exp_link = exp_pc + 32'd4;
    exp_pc  = npc;
    exp_ret = exp_ret + 16'd1;
    @(negedge clk);
    chk("pc_next",    pc, exp_pc);
    chk("retire",     32'(retire_cnt), 32'(exp_ret));
    chk("link_we",    32'(link_we), 32'(b && l));
    chk("link_data",  link_data, exp_link);
    chk("req_next",   32'(imem_req), 32'h1);
    chk("addr_next",  imem_addr, exp_pc);
    chk("ivalid_off", 32'(ivalid), 32'h0);
    ib = 1'b0;
    bl = 1'b0;
    bv = $urandom;
    @(negedge clk);
    chk("link_we_pulse", 32'(link_we), 32'h0);
    chk("req_pending",   32'(imem_req), 32'h1);
  endtask

  initial begin
    rst       = 1'b1;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    ib        = 1'b0;
    bv        = 32'h0;
    bl        = 1'b0;
    stall     = 1'b0;
    exp_pc    = 32'h0;
    exp_link  = 32'h0;
    exp_ret   = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_vals();

    // First request one cycle after IDLE, at address 0
    rst = 1'b0;
    @(negedge clk);
    chk("first_req",    32'(imem_req), 32'h1);
    chk("first_addr",   imem_addr, 32'h0);
    chk("first_ivalid", 32'(ivalid), 32'h0);

    run_instr(2, 32'hE3A0_0001, 1'b0, 1'b0, 32'h0000_0000, 0, 32'h0000_0004);
    run_instr(0, 32'hEA00_0003, 1'b1, 1'b0, 32'h0000_0014, 0, 32'h0000_0020);
    run_instr(1, 32'hEA00_0004, 1'b1, 1'b0, 32'h0000_0010, 0, 32'h0000_0038);
    run_instr(0, 32'hEA00_0030, 1'b1, 1'b0, 32'h0000_00C0, 0, 32'h0000_0100);
    run_instr(1, 32'hEBFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFF8, 0, 32'h0000_0100);
    chk("bl_link_data", link_data, 32'h0000_0104);
    run_instr(0, 32'hEAFF_FFBD, 1'b1, 1'b0, 32'hFFFF_FEF4, 0, 32'hFFFF_FFFC);
    run_instr(0, 32'hE1A0_0000, 1'b0, 1'b0, 32'h0000_0000, 3, 32'h0000_0000);
    chk("retire_total", 32'(retire_cnt), 32'd7);

    // Reset while a fetch is outstanding; the late ack lands in IDLE
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    check_reset_vals();
    @(negedge clk);
    chk("late_ack_iout",   iout, 32'h0);
    chk("late_ack_ivalid", 32'(ivalid), 32'h0);
    chk("late_ack_req",    32'(imem_req), 32'h1);
    chk("late_ack_addr",   imem_addr, 32'h0);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ivalid2", 32'(ivalid), 32'h0);
    chk("late_ack_iout2",   iout, 32'h0);
    exp_pc   = 32'h0;
    exp_link = 32'h0;
    exp_ret  = 16'h0;

    // Stall together with a taken branch-with-link: stall wins, then branch
    run_instr(1, 32'hEB00_0004, 1'b1, 1'b1, 32'h0000_0018, 2, 32'h0000_0020);
    chk("stall_bl_link", link_data, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
